// File: rtl/cache_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : cache_mem_arbiter_if
// Brief   : ICache / DCache refill and memory-port signal bundle.
// Rev     : 1.0
// ============================================================================
interface cache_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128
);
  logic                  icReqValid;
  logic [ADDR_WIDTH-1:0] icReqAddr;
  logic                  icReqReady;
  logic                  icResultValid;
  logic [LINE_WIDTH-1:0] icResultData;

  logic                  dcReqValid;
  logic                  dcReqWE;
  logic [ADDR_WIDTH-1:0] dcReqAddr;
  logic [LINE_WIDTH-1:0] dcReqData;
  logic                  dcReqReady;
  logic                  dcResultValid;
  logic [LINE_WIDTH-1:0] dcResultData;

  logic                  resultError;

  logic                  memReqValid;
  logic                  memReqWE;
  logic [ADDR_WIDTH-1:0] memReqAddr;
  logic [LINE_WIDTH-1:0] memReqData;
  logic                  memReqAck;
  logic                  memResultValid;
  logic [LINE_WIDTH-1:0] memResultData;

  // Arbiter side.
  modport slave (
    input  icReqValid, icReqAddr,
    input  dcReqValid, dcReqWE, dcReqAddr, dcReqData,
    input  memReqAck, memResultValid, memResultData,
    output icReqReady, icResultValid, icResultData,
    output dcReqReady, dcResultValid, dcResultData,
    output resultError,
    output memReqValid, memReqWE, memReqAddr, memReqData
  );

  // Requester / memory side.
  modport master (
    output icReqValid, icReqAddr,
    output dcReqValid, dcReqWE, dcReqAddr, dcReqData,
    output memReqAck, memResultValid, memResultData,
    input  icReqReady, icResultValid, icResultData,
    input  dcReqReady, dcResultValid, dcResultData,
    input  resultError,
    input  memReqValid, memReqWE, memReqAddr, memReqData
  );
endinterface
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : cache_mem_arbiter
// Brief   : Round-robin single-outstanding arbiter of ICache/DCache refills
//           onto one line-wide memory port, with a WAIT watchdog.
// Rev     : 1.0
// ============================================================================
module cache_mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int LINE_WIDTH     = 128,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                clk,
  input logic                rstOut,
  cache_mem_arbiter_if.slave bus
);
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    {{(ADDR_WIDTH - OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  lastGrant_q, lastGrant_d;  // 1 = DCache
  logic                  owner_q, owner_d;          // 1 = DCache
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic [LINE_WIDTH-1:0] rdata_q, rdata_d;

  logic idle;
  logic icWins;
  logic dcWins;

  // On a tie the requester that was not granted last time wins.
  assign idle   = (state_q == S_IDLE);
  assign icWins = bus.icReqValid && (!bus.dcReqValid || lastGrant_q);
  assign dcWins = bus.dcReqValid && (!bus.icReqValid || !lastGrant_q);

  assign bus.icReqReady    = idle && (!bus.dcReqValid || lastGrant_q);
  assign bus.dcReqReady    = idle && (!bus.icReqValid || !lastGrant_q);

  assign bus.memReqValid   = (state_q == S_ISSUE);
  assign bus.memReqWE      = (state_q == S_ISSUE) && we_q;
  assign bus.memReqAddr    = addr_q;
  assign bus.memReqData    = wdata_q;

  assign bus.icResultValid = (state_q == S_RESP) && !owner_q;
  assign bus.dcResultValid = (state_q == S_RESP) && owner_q;
  assign bus.resultError   = (state_q == S_RESP) && err_q;
  assign bus.icResultData  = owner_q ? '0 : rdata_q;
  assign bus.dcResultData  = owner_q ? rdata_q : '0;

  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    owner_d     = owner_q;
    we_d        = we_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (icWins || dcWins) begin
          owner_d     = dcWins;
          lastGrant_d = dcWins;
          we_d        = dcWins && bus.dcReqWE;
          addr_d      = (dcWins ? bus.dcReqAddr : bus.icReqAddr) & ALIGN_MASK;
          wdata_d     = (dcWins && bus.dcReqWE) ? bus.dcReqData : '0;
          err_d       = 1'b0;
          state_d     = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (bus.memReqAck) begin
          if (we_q) begin
            rdata_d = '0;
            state_d = S_RESP;
          end else if (bus.memResultValid) begin
            rdata_d = bus.memResultData;
            state_d = S_RESP;
          end else begin
            cnt_d   = 8'd0;
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (bus.memResultValid) begin
          rdata_d = bus.memResultData;
          state_d = S_RESP;
        end else if (cnt_q == TIMEOUT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstOut) begin
    if (!rstOut) begin
      state_q     <= S_IDLE;
      lastGrant_q <= 1'b0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= 8'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
    end
  end
endmodule
`default_nettype wire
